// File: rtl/pico_pkg.sv
// Shared definitions for the pico core: instruction geometry and the
// program-loader state type. Optional loader feature macro:
// PROG_LOADER_CHECKSUM_EN (see prog_loader.sv).
`ifndef W_INST
`define W_INST 16
`endif

package pico_pkg;

    // Instruction memory address width and instruction word width.
    localparam int unsigned A      = 8;
    localparam int unsigned W_INST = `W_INST;

    // Largest program image (instruction count) that fits the memory.
    localparam logic [31:0] LOAD_LEN_MAX = 32'd1 << A;

    typedef enum logic [2:0] {
        LS_IDLE = 3'd0,
        LS_HDR  = 3'd1,
        LS_LOAD = 3'd2,
        LS_CHK  = 3'd3,
        LS_DONE = 3'd4,
        LS_ERR  = 3'd5
    } loaderState;

    // Length limit for an arbitrary address width.
    function automatic logic [31:0] len_limit(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/prog_loader_ser2par.sv
// Serial-to-parallel word assembler: MSB-first shift register, bit counter
// and a word-valid pulse. The completed word is presented combinationally
// while its last bit is being sampled, so the consumer can act on that edge.
module ser2par #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [W-1:0] word,
    output logic         word_valid
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic [W-2:0] shreg;
    logic [CW-1:0] cnt;
    logic          take;

    assign take       = en & bit_valid;
    assign word       = {shreg, bit_in};
    assign word_valid = take && (cnt == CW'(W - 1));

    // Shift in accepted bits and count position within the current word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clr) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (take) begin
            shreg <= word[W-2:0];
            cnt   <= word_valid ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a length header and instruction words
// bit-serially, writes them to instruction RAM from address 0, then enables
// the core. Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum word (header ^ all payload words) before releasing the core.
module prog_loader
    import pico_pkg::*;
#(
    parameter int unsigned AW = A,
    parameter int unsigned IW = `W_INST
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          bit_i,
    input  logic          bit_valid_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [IW-1:0] wr_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          core_run_o
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam loaderState END_ST = LS_CHK;
`else
    localparam loaderState END_ST = LS_DONE;
`endif

    loaderState    state;
    logic [IW-1:0] len;
    logic [AW:0]   word_cnt;
    logic [IW-1:0] word;
    logic          word_valid;
    logic          start_ok;
    logic          last_word;
    logic          len_over;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [IW-1:0] csum;
`endif

    assign busy_o     = (state == LS_HDR) || (state == LS_LOAD) || (state == LS_CHK);
    assign done_o     = (state == LS_DONE);
    assign core_run_o = (state == LS_DONE);
    assign err_o      = (state == LS_ERR);

    // Restart is only honoured when no load is running.
    assign start_ok  = start_i && ((state == LS_IDLE) || (state == LS_DONE) || (state == LS_ERR));
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);
    assign len_over  = 32'(word) > len_limit(AW);

    ser2par #(
        .W(IW)
    ) u_ser2par (
        .clk       (clk_i),
        .rst       (rst_i),
        .clr       (start_ok),
        .en        (busy_o),
        .bit_in    (bit_i),
        .bit_valid (bit_valid_i),
        .word      (word),
        .word_valid(word_valid)
    );

    // Load sequencing, registered RAM write port and checksum accumulation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= LS_IDLE;
            len       <= '0;
            word_cnt  <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            wr_en_o <= 1'b0;
            if (start_ok) begin
                state    <= LS_HDR;
                word_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (word_valid) begin
                case (state)
                    LS_HDR: begin
                        len <= word;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum <= word;
`endif
                        if (word == '0)
                            state <= END_ST;
                        else if (len_over)
                            state <= LS_ERR;
                        else
                            state <= LS_LOAD;
                    end
                    LS_LOAD: begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= word_cnt[AW-1:0];
                        wr_data_o <= word;
                        word_cnt  <= word_cnt + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum <= csum ^ word;
`endif
                        if (last_word)
                            state <= END_ST;
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    LS_CHK: state <= (word == csum) ? LS_DONE : LS_ERR;
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
